// File: rtl/main_store_pkg.sv
// main_store_pkg
// Shared definitions for the main store serial units (read unit now, write
// unit later): beat FSM state encoding, default geometry, beat length and
// the width of the bit-slot / flyback index.
package main_store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_FLYBACK = 2'd3
  } mru_state_e;

  localparam int MRU_INSTR_BITS   = 20;
  localparam int MRU_FLYBACK_TIME = 4;
  localparam int MRU_ADDR_BITS    = 5;

  // One beat: 1 fetch cycle + INSTR_BITS data slots + (FLYBACK_TIME-1) flyback.
  localparam int BEAT_LEN = MRU_INSTR_BITS + MRU_FLYBACK_TIME;
  localparam int IDX_W    = $clog2(BEAT_LEN) + 1;

  // Index width for a non-default geometry.
  function automatic int beat_idx_w(input int n, input int f);
    return $clog2(n + f) + 1;
  endfunction

endpackage

// File: rtl/main_store_beat_counter.sv
// main_store_beat_counter
// Bit-slot index and flyback cycle counter for one serial beat.
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   state_i        current beat FSM state (main_store_pkg::mru_state_e encoding)
//   bit_sel_o      bit slot being sent this SHIFT cycle
//   idx_last_o     current SHIFT cycle sends the last bit (INSTR_BITS-1)
//   fly_last_o     current FLYBACK cycle is the last one
//   fly_last_nxt_o the next cycle would be the last FLYBACK cycle, if in FLYBACK
module main_store_beat_counter
  import main_store_pkg::*;
#(
  parameter int INSTR_BITS   = MRU_INSTR_BITS,
  parameter int FLYBACK_TIME = MRU_FLYBACK_TIME
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    state_i,
  output logic [$clog2(INSTR_BITS)-1:0] bit_sel_o,
  output logic                          idx_last_o,
  output logic                          fly_last_o,
  output logic                          fly_last_nxt_o
);

  localparam int CNT_W = beat_idx_w(INSTR_BITS, FLYBACK_TIME);
  localparam int BIT_W = $clog2(INSTR_BITS);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(INSTR_BITS - 1);
  localparam logic [CNT_W-1:0] FLY_LAST = CNT_W'(FLYBACK_TIME - 2);

  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] fly_q, fly_d;

  always_comb begin
    idx_d = idx_q;
    fly_d = fly_q;
    case (state_i)
      ST_FETCH: idx_d = '0;             // index only wraps on entry to SHIFT
      ST_SHIFT: begin
        idx_d = idx_q + 1'b1;
        fly_d = '0;                     // first FLYBACK cycle counts as 0
      end
      ST_FLYBACK: begin
        if (fly_q != FLY_LAST) begin
          fly_d = fly_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      fly_q <= '0;
    end else begin
      idx_q <= idx_d;
      fly_q <= fly_d;
    end
  end

  assign bit_sel_o      = idx_q[BIT_W-1:0];
  assign idx_last_o     = (idx_q == IDX_LAST);
  assign fly_last_o     = (fly_q == FLY_LAST);
  assign fly_last_nxt_o = (fly_d == FLY_LAST);

endmodule

// File: rtl/main_store_read_unit.sv
// main_store_read_unit
// Fetches one addressed main store line and shifts it out LSB-first on the
// serial bus feeding the accumulator. A beat is INSTR_BITS+FLYBACK_TIME
// cycles: 1 fetch, INSTR_BITS data slots, FLYBACK_TIME-1 flyback, so bit i
// lands in the same slot the accumulator counters use for bit i.
// Ports:
//   w_CLK          clock, rising edge
//   w_RST_N        asynchronous active-low reset
//   w_XTB          beat-start strobe
//   w_READ_EN      beat starts only if high together with w_XTB
//   b_LINE_ADDR    line to read, sampled when a beat is accepted
//   b_STORE_DATA   store word at b_STORE_ADDR (combinational store read)
//   b_STORE_ADDR   registered line address to the store
//   w_M_DATA_OUT   serial data bit
//   w_M_DATA_VALID high while w_M_DATA_OUT carries a data bit
//   w_BEAT_DONE    one-cycle pulse during the last flyback cycle
// Configuration:
//   MRU_LINE_LATCH_EN  defined: the line is snapshotted when the fetch
//                      completes and shifted from the snapshot, so store
//                      writes during the beat do not affect it. Undefined:
//                      each bit is read live from b_STORE_DATA.
module main_store_read_unit
  import main_store_pkg::*;
#(
  parameter int INSTR_BITS   = MRU_INSTR_BITS,
  parameter int FLYBACK_TIME = MRU_FLYBACK_TIME,
  parameter int ADDR_BITS    = MRU_ADDR_BITS
) (
  input  logic                  w_CLK,
  input  logic                  w_RST_N,
  input  logic                  w_XTB,
  input  logic                  w_READ_EN,
  input  logic [ADDR_BITS-1:0]  b_LINE_ADDR,
  input  logic [INSTR_BITS-1:0] b_STORE_DATA,
  output logic [ADDR_BITS-1:0]  b_STORE_ADDR,
  output logic                  w_M_DATA_OUT,
  output logic                  w_M_DATA_VALID,
  output logic                  w_BEAT_DONE
);

  localparam int BIT_W = $clog2(INSTR_BITS);

  mru_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 done_q, done_d;

  logic [BIT_W-1:0]     bit_sel;
  logic                 idx_last;
  logic                 fly_last;
  logic                 fly_last_nxt;
  logic                 cur_bit;
  logic                 accept;

  main_store_beat_counter #(
    .INSTR_BITS   (INSTR_BITS),
    .FLYBACK_TIME (FLYBACK_TIME)
  ) u_beat_counter (
    .clk_i          (w_CLK),
    .rst_ni         (w_RST_N),
    .state_i        (state_q),
    .bit_sel_o      (bit_sel),
    .idx_last_o     (idx_last),
    .fly_last_o     (fly_last),
    .fly_last_nxt_o (fly_last_nxt)
  );

  assign accept = w_XTB & w_READ_EN;

`ifdef MRU_LINE_LATCH_EN
  logic [INSTR_BITS-1:0] snap_q, snap_d;
  logic                  unused_bit_sel;

  assign unused_bit_sel = ^bit_sel;

  always_comb begin
    snap_d = snap_q;
    if (state_q == ST_FETCH) begin
      snap_d = b_STORE_DATA;            // store address is already stable here
    end else if (state_q == ST_SHIFT) begin
      snap_d = snap_q >> 1;
    end
  end

  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  assign cur_bit = snap_q[0];
`else
  assign cur_bit = b_STORE_DATA[bit_sel];
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = 1'b0;
    vld_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_FETCH;
          addr_d  = b_LINE_ADDR;
        end
      end
      ST_FETCH: state_d = ST_SHIFT;
      ST_SHIFT: begin
        data_d = cur_bit;
        vld_d  = 1'b1;
        if (idx_last) begin
          state_d = ST_FLYBACK;
        end
      end
      ST_FLYBACK: begin
        // Last flyback cycle doubles as the accept slot for the next beat,
        // giving back-to-back beats with no gap.
        if (fly_last) begin
          if (accept) begin
            state_d = ST_FETCH;
            addr_d  = b_LINE_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_FLYBACK) && fly_last_nxt;
  end

  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign b_STORE_ADDR   = addr_q;
  assign w_M_DATA_OUT   = data_q;
  assign w_M_DATA_VALID = vld_q;
  assign w_BEAT_DONE    = done_q;

endmodule

// File: tb/tb_main_store_read_unit.sv
// Testbench for main_store_read_unit: random and directed beats against a
// timeline model of the serial bus, with a scoreboard monitor.
module tb_main_store_read_unit;

  localparam int N    = 20;
  localparam int F    = 4;
  localparam int AW   = 5;
  localparam int BEAT = N + F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          xtb = 1'b0;
  logic          ren = 1'b0;
  logic [AW-1:0] line_addr = '0;
  logic [N-1:0]  store_data;
  logic [AW-1:0] store_addr;
  logic          dout, dvld, done;

  logic [N-1:0]  mem [2**AW];
  assign store_data = mem[store_addr];

  main_store_read_unit #(
    .INSTR_BITS   (N),
    .FLYBACK_TIME (F),
    .ADDR_BITS    (AW)
  ) dut (
    .w_CLK          (clk),
    .w_RST_N        (rst_n),
    .w_XTB          (xtb),
    .w_READ_EN      (ren),
    .b_LINE_ADDR    (line_addr),
    .b_STORE_DATA   (store_data),
    .b_STORE_ADDR   (store_addr),
    .w_M_DATA_OUT   (dout),
    .w_M_DATA_VALID (dvld),
    .w_BEAT_DONE    (done)
  );

  always #5 clk = ~clk;

  // ecount = number of rising edges seen so far.
  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct { int e; int line; int bitn; int start; } bit_t;
  typedef struct { int e; int a; } addr_t;
  typedef struct { int eff; int line; logic [N-1:0] val; } wr_t;

  bit_t  bq[$];
  int    dq[$];
  addr_t aq[$];
  wr_t   wlog[$];

  int            total = 0;
  int            bad = 0;
  int            last_c = -1000;
  logic [AW-1:0] exp_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, ecount, act, exp);
    end
  endtask

  // Store contents seen by the DUT at rising edge e.
  function automatic logic [N-1:0] store_at(input int line, input int e);
    for (int k = wlog.size() - 1; k >= 0; k--) begin
      if (wlog[k].line == line && wlog[k].eff <= e) return wlog[k].val;
    end
    return '0;
  endfunction

  // Called at a falling edge: the write is visible to the next rising edge.
  task automatic store_write(input int line, input logic [N-1:0] v);
    mem[line] = v;
    wlog.push_back('{ecount + 1, line, v});
  endtask

  // A strobe sampled at edge c starts a beat if enabled and the previous beat
  // started at least one beat length earlier (or none is running).
  task automatic model_xtb(input logic r, input logic [AW-1:0] a);
    int c;
    c = ecount + 1;
    if (r && rst_n && c >= last_c + BEAT) begin
      last_c = c;
      aq.push_back('{c, int'(a)});
      for (int i = 0; i < N; i++) bq.push_back('{c + 2 + i, int'(a), i, c});
      dq.push_back(c + BEAT - 1);
    end
  endtask

  task automatic step(input logic x, input logic r, input logic [AW-1:0] a);
    @(negedge clk);
    xtb = x;
    ren = r;
    line_addr = a;
    if (x) model_xtb(r, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'(($urandom) & 1), AW'($urandom));
  endtask

  // Asserted at the current time, between clock edges.
  task automatic do_reset();
    xtb = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dvld), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(store_addr), 32'd0);
    bq.delete();
    dq.delete();
    aq.delete();
    exp_addr = '0;
    last_c = -1000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin : monitor
    logic [N-1:0] w;
    #1;
    while (aq.size() > 0 && aq[0].e <= ecount) begin
      exp_addr = AW'(aq[0].a);
      void'(aq.pop_front());
    end
    chk("store_addr", 32'(store_addr), 32'(exp_addr));
    if (bq.size() > 0 && bq[0].e == ecount) begin
`ifdef MRU_LINE_LATCH_EN
      w = store_at(bq[0].line, bq[0].start + 1);
`else
      w = store_at(bq[0].line, bq[0].e);
`endif
      chk("valid", 32'(dvld), 32'd1);
      chk($sformatf("data_bit%0d", bq[0].bitn), 32'(dout), 32'(w[bq[0].bitn]));
      void'(bq.pop_front());
    end else begin
      chk("idle_valid", 32'(dvld), 32'd0);
      chk("idle_data", 32'(dout), 32'd0);
    end
    if (dq.size() > 0 && dq[0] == ecount) begin
      chk("done", 32'(done), 32'd1);
      void'(dq.pop_front());
    end else begin
      chk("no_done", 32'(done), 32'd0);
    end
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = N'($urandom);
      wlog.push_back('{0, i, mem[i]});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Line 3 = 5: serial 1,0,1,0,...
    idle(2);
    store_write(3, 20'h00005);
    step(1'b1, 1'b1, 5'd3);
    idle(30);

    // Back-to-back beats on lines 0..3.
    store_write(0, 20'h0F0F0);
    store_write(1, 20'hA5A5A);
    store_write(2, 20'h12345);
    store_write(3, 20'hFEDCB);
    step(1'b1, 1'b1, 5'd0);
    for (int b = 1; b < 4; b++) begin
      idle(BEAT - 1);
      step(1'b1, 1'b1, AW'(b));
    end
    idle(30);

    // Strobe with READ_EN low.
    step(1'b1, 1'b0, 5'd7);
    idle(30);

    // Strobe mid-SHIFT with a different line.
    step(1'b1, 1'b1, 5'd5);
    idle(9);
    step(1'b1, 1'b1, 5'd9);
    idle(30);

    // Store word changes to all ones just before bit 10 is sent.
    store_write(6, 20'h0A5A5);
    step(1'b1, 1'b1, 5'd6);
    idle(12);
    store_write(6, 20'hFFFFF);
    idle(30);

    // Reset while bit 7 is on the bus.
    step(1'b1, 1'b1, 5'd2);
    idle(10);
    do_reset();
    idle(10);
    step(1'b1, 1'b1, 5'd2);
    idle(30);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) store_write(int'($urandom_range(0, 2**AW - 1)), N'($urandom));
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else if (ecount + 1 == last_c + BEAT && ($urandom & 1) == 1) begin
        step(1'b1, ($urandom_range(0, 3) != 0), AW'($urandom));
      end else if ($urandom_range(0, 7) == 0) begin
        step(1'b1, ($urandom_range(0, 3) != 0), AW'($urandom));
      end else begin
        step(1'b0, 1'(($urandom) & 1), AW'($urandom));
      end
    end
    idle(40);
    chk("pending_expectations", 32'(bq.size() + dq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
